// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ writeback sources.
// Define RF_WB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr_ptr).
module rf_wb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      stall,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         Write_Reg,
    output logic [DATA_W-1:0]         Write_Data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    logic [IdW-1:0] search_start;
    logic [IdW-1:0] gnt_idx;
    logic           gnt_found;
    logic           xfer;

`ifdef RF_WB_ARB_FIXED_PRIO_EN
    assign search_start = '0;
`else
    logic [IdW-1:0] rr_ptr_q;
    logic [IdW-1:0] rr_ptr_d;

    assign search_start = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Search NUM_REQ slots starting at search_start, wrapping at NUM_REQ-1.
    always_comb begin
        logic [IdW:0]   sum;
        logic [IdW-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            sum = {1'b0, search_start} + (IdW+1)'(k);
            if (sum >= (IdW+1)'(NUM_REQ)) begin
                sum = sum - (IdW+1)'(NUM_REQ);
            end
            idx = sum[IdW-1:0];
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    assign xfer = gnt_found & ~stall;

    always_comb begin
        req_ready = '0;
        if (xfer && rst_n) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    logic                regwrite_q, regwrite_d;
    logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic [IdW-1:0]      grant_id_q, grant_id_d;

    // Writes to x0 still take the slot but never assert the write enable.
    always_comb begin
        regwrite_d   = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        grant_id_d   = grant_id_q;
        if (xfer) begin
            regwrite_d   = (addr_arr[gnt_idx] != '0);
            write_reg_d  = addr_arr[gnt_idx];
            write_data_d = data_arr[gnt_idx];
            grant_id_d   = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            grant_id_q   <= '0;
        end else begin
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign RegWrite   = regwrite_q;
    assign Write_Reg  = write_reg_q;
    assign Write_Data = write_data_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (default round-robin build, NUM_REQ=3).
module tb_rf_wb_arbiter;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      stall;
    logic                      RegWrite;
    logic [ADDR_W-1:0]         Write_Reg;
    logic [DATA_W-1:0]         Write_Data;
    logic [1:0]                grant_id;

    int checks;
    int failures;

    rf_wb_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .stall     (stall),
        .RegWrite  (RegWrite),
        .Write_Reg (Write_Reg),
        .Write_Data(Write_Data),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] rr_data [3];
    logic [ADDR_W-1:0] rr_addr [3];

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        stall     = 1'b0;
        req_valid = 3'b111;
        req_addr  = '0;
        req_data  = '0;
        rr_addr[0] = 5'd1;  rr_data[0] = 32'h0000_0100;
        rr_addr[1] = 5'd2;  rr_data[1] = 32'h0000_0200;
        rr_addr[2] = 5'd3;  rr_data[2] = 32'h0000_0300;
        for (int i = 0; i < 3; i++) set_req(i, rr_addr[i], rr_data[i]);

        // Reset held with all requests valid.
        step();
        step();
        check_eq("rst_ready", 64'(req_ready), 64'h0);
        check_eq("rst_regwrite", 64'(RegWrite), 64'h0);
        check_eq("rst_write_reg", 64'(Write_Reg), 64'h0);
        check_eq("rst_write_data", 64'(Write_Data), 64'h0);
        check_eq("rst_grant_id", 64'(grant_id), 64'h0);

        // Round-robin from reset release: 0,1,2,0,1,2.
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("rr_ready_%0d", i), 64'(req_ready), 64'(3'b001 << (i % 3)));
            step();
            check_eq($sformatf("rr_gid_%0d", i), 64'(grant_id), 64'(i % 3));
            check_eq($sformatf("rr_we_%0d", i), 64'(RegWrite), 64'h1);
            check_eq($sformatf("rr_reg_%0d", i), 64'(Write_Reg), 64'(rr_addr[i % 3]));
            check_eq($sformatf("rr_data_%0d", i), 64'(Write_Data), 64'(rr_data[i % 3]));
        end

        // Idle: enable drops, payload holds.
        req_valid = 3'b000;
        step();
        check_eq("idle_we", 64'(RegWrite), 64'h0);
        check_eq("idle_gid_hold", 64'(grant_id), 64'h2);
        check_eq("idle_data_hold", 64'(Write_Data), 64'h300);

        // Single requester 1 (rr_ptr=0), then back-to-back throughput.
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        check_eq("single_ready", 64'(req_ready), 64'b010);
        step();
        check_eq("single_we", 64'(RegWrite), 64'h1);
        check_eq("single_reg", 64'(Write_Reg), 64'd5);
        check_eq("single_data", 64'(Write_Data), 64'hDEAD_BEEF);
        check_eq("single_gid", 64'(grant_id), 64'h1);
        set_req(1, 5'd6, 32'hCAFE_0001);
        #1;
        check_eq("thru_ready", 64'(req_ready), 64'b010);
        step();
        check_eq("thru_we", 64'(RegWrite), 64'h1);
        check_eq("thru_data", 64'(Write_Data), 64'hCAFE_0001);

        // x0 discard from requester 2 (rr_ptr=2).
        set_req(2, 5'd0, 32'h0000_1234);
        req_valid = 3'b100;
        #1;
        check_eq("x0_ready", 64'(req_ready), 64'b100);
        step();
        check_eq("x0_we", 64'(RegWrite), 64'h0);
        check_eq("x0_gid", 64'(grant_id), 64'h2);
        check_eq("x0_data", 64'(Write_Data), 64'h1234);
        set_req(0, 5'd10, 32'h0000_00AA);
        set_req(2, 5'd9, 32'h0000_00CC);
        req_valid = 3'b101;
        #1;
        check_eq("post_x0_ready", 64'(req_ready), 64'b001);
        step();
        check_eq("post_x0_gid", 64'(grant_id), 64'h0);

        // Stall with reqs 0 and 2 pending, rr_ptr=1.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("stall_ready_%0d", i), 64'(req_ready), 64'h0);
            step();
            check_eq($sformatf("stall_we_%0d", i), 64'(RegWrite), 64'h0);
        end
        stall = 1'b0;
        #1;
        check_eq("unstall_ready_a", 64'(req_ready), 64'b100);
        step();
        check_eq("unstall_gid_a", 64'(grant_id), 64'h2);
        check_eq("unstall_data_a", 64'(Write_Data), 64'hCC);
        req_valid = 3'b001;
        #1;
        check_eq("unstall_ready_b", 64'(req_ready), 64'b001);
        step();
        check_eq("unstall_gid_b", 64'(grant_id), 64'h0);
        check_eq("unstall_data_b", 64'(Write_Data), 64'hAA);

        // Bring rr_ptr back to 0 via a grant to requester 2.
        req_valid = 3'b100;
        step();
        check_eq("wrap_gid", 64'(grant_id), 64'h2);

        // Same destination x7: 0xA then 0xB.
        set_req(0, 5'd7, 32'h0000_000A);
        set_req(1, 5'd7, 32'h0000_000B);
        req_valid = 3'b011;
        #1;
        check_eq("same_ready_a", 64'(req_ready), 64'b001);
        step();
        check_eq("same_data_a", 64'(Write_Data), 64'hA);
        check_eq("same_reg_a", 64'(Write_Reg), 64'd7);
        req_valid = 3'b010;
        step();
        check_eq("same_data_b", 64'(Write_Data), 64'hB);
        check_eq("same_we_b", 64'(RegWrite), 64'h1);
        check_eq("same_gid_b", 64'(grant_id), 64'h1);

        // Asynchronous reset in the middle of a registered write.
        set_req(0, 5'd4, 32'h0000_0044);
        req_valid = 3'b001;
        step();
        check_eq("mid_we_before", 64'(RegWrite), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_we_dropped", 64'(RegWrite), 64'h0);
        check_eq("mid_ready", 64'(req_ready), 64'h0);
        check_eq("mid_data_clr", 64'(Write_Data), 64'h0);

        // Release: search restarts from index 0.
        req_valid = 3'b111;
        step();
        rst_n = 1'b1;
        #1;
        check_eq("rel_ready", 64'(req_ready), 64'b001);
        step();
        check_eq("rel_gid", 64'(grant_id), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
